// File: rtl/bcd_tick_counter_if.sv
// Control inputs and display/count outputs of the BCD tick counter.
interface bcd_tick_counter_if;
   logic        tick_in;
   logic        run;
   logic        up;
   logic        clear;
   logic [15:0] count;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;

   modport master (output tick_in, run, up, clear, input count, seg, an, dp);
   modport slave  (input tick_in, run, up, clear, output count, seg, an, dp);
endinterface

// File: rtl/bcd_tick_counter.sv
// Four-digit BCD up/down counter of tick_in rising edges, scanned onto a
// common-anode seven-segment display; dp on digit 0 flags a wrap.
module bcd_tick_counter #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   bcd_tick_counter_if.slave   bus
);
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic          tick_prev_q;
   logic [15:0]   count_q, count_d;
   logic          wrap_q, wrap_d;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          tick_rise;
   logic          carry;
   logic [3:0]    dig;
   logic [3:0]    cur_digit;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h7F;
      endcase
   endfunction

   assign tick_rise = bus.tick_in & ~tick_prev_q;

   // Ripple a single +1/-1 through the digits; a carry out of d3 is a wrap.
   always_comb begin
      count_d = count_q;
      wrap_d  = wrap_q;
      carry   = 1'b0;
      dig     = 4'd0;
      if (bus.clear) begin
         count_d = 16'h0000;
         wrap_d  = 1'b0;
      end else if (tick_rise && bus.run) begin
         carry = 1'b1;
         for (int i = 0; i < 4; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
               if (bus.up) begin
                  if (dig == 4'd9) dig = 4'd0;
                  else begin dig = dig + 4'd1; carry = 1'b0; end
               end else begin
                  if (dig == 4'd0) dig = 4'd9;
                  else begin dig = dig - 4'd1; carry = 1'b0; end
               end
            end
            count_d[4*i +: 4] = dig;
         end
         if (carry) wrap_d = 1'b1;
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      idx_d      = idx_q;
      if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         tick_prev_q <= 1'b0;
         count_q     <= 16'h0000;
         wrap_q      <= 1'b0;
         scan_cnt_q  <= '0;
         idx_q       <= 2'd0;
      end else begin
         tick_prev_q <= bus.tick_in;
         count_q     <= count_d;
         wrap_q      <= wrap_d;
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
      end
   end

   assign cur_digit = count_q[4*idx_q +: 4];
   assign bus.count = count_q;
   assign bus.seg   = decode(cur_digit);
   assign bus.an    = ~(4'b0001 << idx_q);
   assign bus.dp    = ~((idx_q == 2'd0) & wrap_q);
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter with a short scan dwell.
module tb_bcd_tick_counter;
   localparam int unsigned SCAN_DIV = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   bcd_tick_counter_if bus ();

   bcd_tick_counter #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulses(input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         bus.tick_in = 1'b1;
         repeat (hi) @(negedge clk);
         bus.tick_in = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   // Advance until the display reaches the requested digit enable.
   task automatic wait_an(input logic [3:0] target, input string tag);
      int n;
      n = 0;
      while (bus.an !== target && n < 32) begin
         @(negedge clk);
         n++;
      end
      if (bus.an !== target) chk({tag, "_timeout"}, {28'd0, bus.an}, {28'd0, target});
   endtask

   // Align to the first cycle of the digit-0 dwell.
   task automatic align_idx0(input string tag);
      wait_an(4'b0111, tag);
      wait_an(4'b1110, tag);
   endtask

   logic [3:0] exp_an  [4];
   logic [6:0] exp_seg [4];

   initial begin
      bus.tick_in = 1'b0;
      bus.run     = 1'b0;
      bus.up      = 1'b1;
      bus.clear   = 1'b0;
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};

      repeat (2) @(negedge clk);
      chk("rst_count", {16'd0, bus.count}, 32'h0);
      chk("rst_an",    {28'd0, bus.an}, 32'b1110);
      chk("rst_seg",   {25'd0, bus.seg}, 32'h40);
      chk("rst_dp",    {31'd0, bus.dp}, 32'd1);
      reset_n = 1'b1;
      @(negedge clk);

      // Up counting and single event per held-high tick
      bus.run = 1'b1;
      bus.up  = 1'b1;
      pulses(12, 2, 2);
      chk("up12", {16'd0, bus.count}, 32'h0012);
      bus.tick_in = 1'b1;
      repeat (50) @(negedge clk);
      bus.tick_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("hold_high", {16'd0, bus.count}, 32'h0013);

      // Asynchronous reset mid-count
      pulses(334, 1, 1);
      chk("pre_rst", {16'd0, bus.count}, 32'h0347);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_count", {16'd0, bus.count}, 32'h0);
      chk("arst_an",    {28'd0, bus.an}, 32'b1110);
      chk("arst_seg",   {25'd0, bus.seg}, 32'h40);
      chk("arst_dp",    {31'd0, bus.dp}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_dwell3", {28'd0, bus.an}, 32'b1110);
      @(negedge clk);
      chk("rst_dwell4", {28'd0, bus.an}, 32'b1101);

      // Up wrap 9999 -> 0000 and sticky wrap indicator
      pulses(9999, 1, 1);
      chk("at9999", {16'd0, bus.count}, 32'h9999);
      align_idx0("pre_wrap");
      chk("pre_wrap_dp", {31'd0, bus.dp}, 32'd1);
      chk("pre_wrap_seg", {25'd0, bus.seg}, 32'h10);
      pulses(1, 1, 1);
      chk("wrap_up", {16'd0, bus.count}, 32'h0000);
      align_idx0("wrap_dp");
      for (int i = 0; i < 16; i++) begin
         chk("wrap_an", {28'd0, bus.an}, {28'd0, exp_an[(i/4)%4]});
         chk("wrap_dp", {31'd0, bus.dp}, ((i/4)%4 == 0) ? 32'd0 : 32'd1);
         @(negedge clk);
      end
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("clr_dp", {31'd0, bus.dp}, 32'd1);
         @(negedge clk);
      end

      // Down wrap, borrow, run gating
      bus.up = 1'b0;
      pulses(1, 1, 1);
      chk("down_wrap", {16'd0, bus.count}, 32'h9999);
      align_idx0("down_dp");
      chk("down_dp", {31'd0, bus.dp}, 32'd0);
      pulses(1, 1, 1);
      chk("down_9998", {16'd0, bus.count}, 32'h9998);
      bus.run = 1'b0;
      pulses(5, 1, 1);
      chk("run_gate", {16'd0, bus.count}, 32'h9998);
      bus.run = 1'b1;

      // Clear beats a simultaneous tick edge
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      bus.up = 1'b1;
      pulses(99, 1, 1);
      chk("pre_clr", {16'd0, bus.count}, 32'h0099);
      bus.clear   = 1'b1;
      bus.tick_in = 1'b1;
      @(negedge clk);
      chk("clr_prio", {16'd0, bus.count}, 32'h0000);
      bus.clear = 1'b0;
      @(negedge clk);
      chk("clr_lost", {16'd0, bus.count}, 32'h0000);
      bus.tick_in = 1'b0;
      @(negedge clk);

      // Scan sequence on 1234
      pulses(1234, 1, 1);
      chk("scan_val", {16'd0, bus.count}, 32'h1234);
      align_idx0("scan");
      for (int i = 0; i < 32; i++) begin
         chk("scan_an",  {28'd0, bus.an},  {28'd0, exp_an[(i/4)%4]});
         chk("scan_seg", {25'd0, bus.seg}, {25'd0, exp_seg[(i/4)%4]});
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Four-digit BCD up/down event counter with multiplexed seven-segment drive, sitting directly downstream of the lab clock divider. It samples the divider's slow square wave on the system clock and counts each rising edge as one event. It holds a packed-BCD value 0000–9999 and scans it onto a 4-digit common-anode display. The design uses a single clock domain; the divided wave is treated as data, never as a clock.

## Interface

- SCAN_DIV, 100000: clk cycles each digit stays enabled during the display scan; legal range ≥ 2.
- clk  in  1  system clock (100 MHz on board).
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values.
- tick_in  in  1  divided square wave from the clock divider, synchronous to clk; each 0→1 transition is one count event.
- run  in  1  level; 1 enables counting, 0 ignores ticks.
- up  in  1  direction; 1 counts up, 0 counts down.
- clear  in  1  synchronous clear, level-sensitive.
- count  out  16  packed BCD {d3,d2,d1,d0}; d0 is the ones digit.
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g.
- an  out  4  active-low digit enables; an[0] drives d0.
- dp  out  1  active-low decimal point; used as the wrap indicator.

## Operation

- Edge detect: tick_prev samples tick_in every clk. tick_rise = tick_in & ~tick_prev. tick_prev resets to 0, so tick_in=1 at reset release produces one event.
- Count update per clk edge, with this priority:
  - clear=1: count←0000, wrap_flag←0. Any tick is discarded.
  - else, if tick_rise & run, apply a BCD step:
    - up=1: d0+1, with carry ripple at 9→0 into d1, d2, d3. 9999→0000 sets wrap_flag.
    - up=0: d0−1, with borrow ripple at 0→9. 0000→9999 sets wrap_flag.
  - else: hold.
- wrap_flag is sticky. Only clear or reset clears it.
- Digits never hold codes A–F. The decoder maps any such code to all segments off (7'h7F).
- Scan: scan_cnt runs 0..SCAN_DIV−1. On the terminal value it returns to 0 and idx (2 bits) advances 0→1→2→3→0.
- an = ~(4'b0001 << idx). seg = decode(digit[idx]).
- dp = 0 only when idx=0 and wrap_flag=1; otherwise 1.
- Segment codes, hex with seg[6] as MSB: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
- Changing up, run or clear mid-scan has no effect on the scan sequence.

## Timing

- Registered state: tick_prev, count, wrap_flag, scan_cnt, idx.
- seg, an and dp are combinational from registered state only. A count change is visible on seg in the same cycle count changes.
- Latency: count updates at the first clk rising edge where tick_in=1 and tick_prev=0 are sampled. A tick_in held high for N cycles produces exactly one event.
- Minimum tick spacing: tick_in must be low for ≥1 clk between events.
- Reset values (applied asynchronously on reset=0, with no clock needed): count=16'h0000, wrap_flag=0, scan_cnt=0, idx=0, tick_prev=0. This gives an=4'b1110, seg=7'h40, dp=1.
- Reset deasserts synchronously to clk externally. The first edge after release is a normal cycle.
- Simultaneous clear and tick_rise: clear wins and the event is lost.
- Reset mid-scan restarts the scan at idx 0 with a full SCAN_DIV dwell.

## Test plan

- Reset: drive reset=0 mid-count (count=0x0347), asynchronously with no clk edge -> count=0x0000, an=1110, seg=0x40, dp=1 immediately.
- Up count: run=1, up=1, 12 tick pulses (2 cycles high, 2 low) -> count=0x0012. Hold tick_in high for 50 cycles -> count=0x0013 only.
- Up wrap: 10000 pulses from 0000 -> count=0x0000, dp=0 whenever an=1110, dp=1 on the other digits. Then clear=1 for one cycle -> dp=1 on all digits.
- Down wrap and run gating: up=0, one pulse from 0000 -> 0x9999 with the wrap flag set. Next pulse -> 0x9998. run=0 with 5 pulses -> still 0x9998.
- Clear priority: clear=1 in the same cycle as tick_rise with count=0x0099 -> count=0x0000 and no increment.
- Scan: SCAN_DIV=4, count=0x1234 -> an sequence 1110, 1101, 1011, 0111, 4 cycles each and repeating, with seg=0x19, 0x30, 0x24, 0x79 respectively.
